// File: rtl/stream_mux_n_to_1.sv
// Registered N:1 stream multiplexer with valid/ready handshakes, fixed-select or
// round-robin arbitration, packet locking and a data path built from slice muxes.
module stream_mux_n_to_1 #(
   parameter int N       = 4,
   parameter int WIDTH   = 8,
   parameter int SLICE_W = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [$clog2(N)-1:0] sel,
   input  logic [N-1:0]         in_valid,
   input  logic [N-1:0]         in_last,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic                 out_last,
   output logic [WIDTH-1:0]     out_data,
   input  logic                 out_ready
);

   localparam int SW = $clog2(N);
   localparam int NS = WIDTH / SLICE_W;

   generate
      if (WIDTH % SLICE_W != 0) begin : g_bad_slice
         $error("stream_mux_n_to_1: WIDTH must be a multiple of SLICE_W");
      end
   endgenerate

   logic [SW-1:0]    ptr;
   logic             lock;
   logic [SW-1:0]    lock_ch;
   logic             load;
   logic             grant_vld;
   logic [SW-1:0]    g;
   logic             xfer;
   logic             last_sel;
   logic [WIDTH-1:0] mux_data;
   int unsigned      idx;

   assign load = !out_valid || out_ready;

   // Lock overrides everything so a multi-beat packet is never interleaved.
   always_comb begin
      grant_vld = 1'b0;
      g         = '0;
      idx       = 0;
      if (lock) begin
         grant_vld = 1'b1;
         g         = lock_ch;
      end else if (!mode) begin
         grant_vld = (int'(sel) < N);
         g         = sel;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!grant_vld && in_valid[SW'(idx)]) begin
               grant_vld = 1'b1;
               g         = SW'(idx);
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      last_sel = 1'b0;
      for (int unsigned c = 0; c < N; c++) begin
         in_ready[c] = load && grant_vld && (g == SW'(c));
         if (g == SW'(c)) last_sel = in_last[c];
      end
   end

   assign xfer = |(in_valid & in_ready);

   for (genvar k = 0; k < NS; k++) begin : g_slice
      logic [SLICE_W-1:0] sd;
      always_comb begin
         sd = '0;
         for (int unsigned c = 0; c < N; c++) begin
            if (g == SW'(c)) sd = in_data[c*WIDTH + k*SLICE_W +: SLICE_W];
         end
      end
      assign mux_data[k*SLICE_W +: SLICE_W] = sd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         ptr       <= '0;
         lock      <= 1'b0;
         lock_ch   <= '0;
      end else begin
         if (load) out_valid <= xfer;
         if (xfer) begin
            out_data <= mux_data;
            out_last <= last_sel;
            lock     <= !last_sel;
            lock_ch  <= g;
            if (last_sel) ptr <= (g == SW'(N-1)) ? '0 : g + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// Scoreboard bench for stream_mux_n_to_1: a reference grant model predicts
// in_ready and queues expected beats, which are popped on output handshakes.
module tb_stream_mux_n_to_1;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [1:0]  sel;
   logic [3:0]  in_valid, in_last, in_ready;
   logic [31:0] in_data;
   logic        out_valid, out_last, out_ready;
   logic [7:0]  out_data;

   logic        mode12;
   logic [1:0]  sel12;
   logic [3:0]  v12, l12, r12;
   logic [47:0] d12;
   logic        ov12, ol12, ordy12;
   logic [11:0] od12;

   logic [7:0]  d [4];
   logic [8:0]  sbq [$];
   logic [7:0]  seen [$];
   logic        mov, mlock;
   logic [1:0]  mptr, mlch;
   int          n_checks = 0;
   int          n_errors = 0;

   logic [7:0]  rr_exp [5]   = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h00};
   logic [7:0]  lock_exp [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hC2};

   always #5 clk = ~clk;

   stream_mux_n_to_1 #(.N(4), .WIDTH(8), .SLICE_W(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_ready(out_ready)
   );

   stream_mux_n_to_1 #(.N(4), .WIDTH(12), .SLICE_W(4)) u_dut12 (
      .clk(clk), .rst_n(rst_n), .mode(mode12), .sel(sel12),
      .in_valid(v12), .in_last(l12), .in_data(d12), .in_ready(r12),
      .out_valid(ov12), .out_last(ol12), .out_data(od12), .out_ready(ordy12)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic reset_model();
      mov   = 1'b0;
      mlock = 1'b0;
      mptr  = '0;
      mlch  = '0;
      sbq.delete();
      seen.delete();
   endtask

   // Called just after a falling edge with inputs set; returns at the next falling edge.
   task automatic tick();
      logic       mgv, ld, xf;
      logic [1:0] mg;
      logic [8:0] e;
      in_data = {d[3], d[2], d[1], d[0]};
      #2;
      check("out_valid", out_valid, mov);
      if (out_valid && out_ready) begin
         check("sb_nonempty", sbq.size() != 0, 1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("out_beat", {out_last, out_data}, e);
            seen.push_back(out_data);
         end
      end
      mgv = 1'b0;
      mg  = '0;
      if (mlock) begin
         mgv = 1'b1;
         mg  = mlch;
      end else if (!mode) begin
         mgv = 1'b1;
         mg  = sel;
      end else begin
         for (int i = 0; i < N; i++) begin
            int c;
            c = (int'(mptr) + i) % N;
            if (!mgv && in_valid[2'(c)]) begin
               mgv = 1'b1;
               mg  = 2'(c);
            end
         end
      end
      ld = !mov || out_ready;
      check("in_ready", in_ready, (mgv && ld) ? (4'b0001 << mg) : 4'b0000);
      xf = mgv && ld && in_valid[mg];
      if (xf) sbq.push_back({in_last[mg], d[mg]});
      @(posedge clk);
      if (ld) mov = xf;
      if (xf) begin
         if (in_last[mg]) begin
            mlock = 1'b0;
            mptr  = mg + 2'd1;
         end else begin
            mlock = 1'b1;
            mlch  = mg;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; mode = 1'b0; sel = 2'd2;
      in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) d[i] = '0;
      mode12 = 1'b0; sel12 = '0; v12 = '0; l12 = '0; d12 = '0; ordy12 = 1'b1;
      reset_model();
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
      rst_n = 1'b1;

      // Fixed select streaming from channel 2
      in_valid = 4'b0100; in_last = 4'b0100;
      d[2] = 8'hA5; tick();
      d[2] = 8'h3C; tick();
      in_valid = '0; tick(); tick();
      check("m0_beat0", seen.size() > 0 ? seen[0] : 8'hxx, 8'hA5);
      check("m0_beat1", seen.size() > 1 ? seen[1] : 8'hxx, 8'h3C);
      seen.delete();

      // Back-pressure: held beat stays put, next beat accepted on release
      in_valid = 4'b0100; d[2] = 8'h5A; tick();
      out_ready = 1'b0; d[2] = 8'h77;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold", out_data, 8'h5A);
         check("bp_ready", in_ready, 4'b0000);
      end
      out_ready = 1'b1; tick();
      check("bp_next", {out_valid, out_data}, {1'b1, 8'h77});
      in_valid = '0; tick();
      seen.delete();

      // Asynchronous reset mid-cycle with a buffered beat
      in_valid = 4'b0100; d[2] = 8'h99; out_ready = 1'b0; tick();
      #1 rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_out_last", out_last, 0);
      check("arst_out_data", out_data, 0);
      reset_model();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin with every channel valid and single-beat packets
      mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) d[i] = 8'(i * 16);
      for (int i = 0; i < 5; i++) tick();
      in_valid = '0; tick();
      for (int i = 0; i < 5; i++)
         check("rr_order", seen.size() > i ? seen[i] : 8'hxx, rr_exp[i]);
      seen.delete();

      // Packet lock on channel 1 while sel and mode change underneath it
      mode = 1'b0; sel = 2'd1; in_valid = 4'b0111; in_last = 4'b0101;
      d[0] = 8'hE0; d[1] = 8'hB1; d[2] = 8'hC2; tick();
      sel = 2'd0; d[1] = 8'hB2; tick();
      mode = 1'b1; sel = 2'd2; in_last = 4'b0111; d[1] = 8'hB3; tick();
      tick();
      in_valid = '0; tick();
      for (int i = 0; i < 4; i++)
         check("lock_order", seen.size() > i ? seen[i] : 8'hxx, lock_exp[i]);
      seen.delete();

      // Slice integrity on a 12-bit instance with 4-bit slices
      sel12 = 2'd3; v12 = 4'b1111; l12 = 4'b1111;
      d12 = {12'hABC, 12'h456, 12'h789, 12'h123};
      @(posedge clk);
      @(negedge clk);
      check("slice_ch3", {ov12, od12}, {1'b1, 12'hABC});
      sel12 = 2'd0;
      #1;
      check("slice_ready", r12, 4'b0001);
      @(posedge clk);
      @(negedge clk);
      check("slice_ch0", od12, 12'h123);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
